// File: rtl/mdu_if.sv
// Port bundle between the execute stage and mul_div_unit.
// Handshake: the pipeline holds start (with op/a/b stable) high while busy is
// high; the result is delivered with a one-cycle hilo_we strobe. Once that
// strobe has fired and busy is low, the pipeline advances on the next edge.
// fsm_state exposes the unit's FSM state for observation.
interface mdu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       fsm_state;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hilo_we, hi, lo, fsm_state
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hilo_we, hi, lo, fsm_state
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the execute stage.
// Iterative shift-add multiply and restoring radix-2 divide, one bit per cycle.
// Optional macro MDU_FAST_MUL_EN: multiplies complete combinationally in the
// acceptance cycle using an array multiply; divides are unaffected.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;      // partial remainder / product high half
    logic [WIDTH-1:0] q;        // dividend->quotient / multiplier->product low half
    logic [WIDTH-1:0] m;        // divisor or multiplicand magnitude
    logic [WIDTH-1:0] a_saved;  // raw dividend, returned in hi on divide by zero
    logic             is_div, neg_lo, neg_hi, div_zero;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] hi_out, lo_out, res_hi, res_lo;
    logic             we_out;

    logic             accept, fast_go, iter_accept;
    logic             is_signed, a_neg, b_neg;
    logic [WIDTH:0]   div_shift, div_diff, mul_sum;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;

    assign accept      = (state == IDLE) && bus.start && !bus.cancel;
`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_ax, fast_bx, fast_prod;
    assign fast_go   = accept && !bus.op[1];
    // Sign-extend to 2*WIDTH so one unsigned multiply serves both MULT and MULTU.
    assign fast_ax   = {{WIDTH{bus.a[WIDTH-1] & ~bus.op[0]}}, bus.a};
    assign fast_bx   = {{WIDTH{bus.b[WIDTH-1] & ~bus.op[0]}}, bus.b};
    assign fast_prod = fast_ax * fast_bx;
`else
    assign fast_go   = 1'b0;
`endif
    assign iter_accept = accept && !fast_go;

    assign is_signed = !bus.op[0];
    assign a_neg     = is_signed && bus.a[WIDTH-1];
    assign b_neg     = is_signed && bus.b[WIDTH-1];

    // One restoring-divide step and one shift-add multiply step.
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m};
    assign mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? m : {WIDTH{1'b0}})};

    assign prod_raw  = {acc, q};
    assign prod_fix  = neg_lo ? -prod_raw : prod_raw;

    // Final sign correction and divide-by-zero override, valid in DONE.
    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = a_saved;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = neg_hi ? -acc : acc;
                res_lo = neg_lo ? -q : q;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state; DONE always returns to IDLE so a held start is not re-taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (iter_accept) state_next = BUSY;
            BUSY: begin
                if (bus.cancel)                     state_next = IDLE;
                else if (count == CW'(WIDTH - 1))   state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on acceptance, then one iteration per BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            a_saved  <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (iter_accept) begin
                count    <= '0;
                acc      <= '0;
                q        <= a_neg ? -bus.a : bus.a;
                m        <= b_neg ? -bus.b : bus.b;
                a_saved  <= bus.a;
                is_div   <= bus.op[1];
                neg_lo   <= a_neg ^ b_neg;
                neg_hi   <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
                div_zero <= bus.op[1] && (bus.b == '0);
            end
        end else if (state == BUSY) begin
            count <= count + 1'b1;
            if (is_div) begin
                if (!div_diff[WIDTH]) begin
                    acc <= div_diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= div_shift[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc <= mul_sum[WIDTH:1];
                q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
        end
    end

    // Output mux: result in DONE (or fast multiply), held registers otherwise.
    always_comb begin
        we_out = 1'b0;
        hi_out = hi_q;
        lo_out = lo_q;
        if (state == DONE) begin
            we_out = 1'b1;
            hi_out = res_hi;
            lo_out = res_lo;
        end
`ifdef MDU_FAST_MUL_EN
        if (fast_go) begin
            we_out = 1'b1;
            hi_out = fast_prod[2*WIDTH-1:WIDTH];
            lo_out = fast_prod[WIDTH-1:0];
        end
`endif
    end

    // Hold registers keep the last written result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_out) begin
            hi_q <= hi_out;
            lo_q <= lo_out;
        end
    end

    assign bus.busy      = iter_accept || (state == BUSY);
    assign bus.hilo_we   = we_out;
    assign bus.hi        = hi_out;
    assign bus.lo        = lo_out;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: spec vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written cancel/reset/chaining sequences.
module tb_mul_div_unit;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] exp_q[$];

    mdu_if #(.WIDTH(W)) bus ();
    mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Clock / reset.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model from the arithmetic rules, not the datapath.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic int exp_busy(input logic [1:0] op);
        return (FAST && !op[1]) ? 0 : W + 1;
    endfunction

    // Driver: issue one op, hold start until the hilo_we cycle, report result.
    // keep=1 leaves start high so the caller can chain the next op immediately.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit keep, output logic [63:0] res, output int busy_n);
        bit done;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cancel = 1'b0;
        busy_n = 0; done = 1'b0; res = '0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.hilo_we) begin
                res = {bus.hi, bus.lo};
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL timeout: no hilo_we for op %0d got busy=%0d expected strobe", op, busy_n);
        end
        if (!keep) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            check("post_idle_state", 64'(bus.fsm_state), 64'd0);
            check("post_no_we", 64'(bus.hilo_we), 64'd0);
            check("post_hold", {bus.hi, bus.lo}, res);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [63:0] res, res2;
        int bn, bn2;
        logic [63:0] held;

        vecs[0] = '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[1] = '{2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2};
        vecs[2] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        vecs[3] = '{2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
        vecs[4] = '{2'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'hFFFF_FFFD};
        vecs[6] = '{2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[7] = '{2'd2, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2};

        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_we", 64'(bus.hilo_we), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 64'(bus.fsm_state), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

        // Specification vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, bn);
            check($sformatf("vec%0d_result", i), res, {vecs[i].exp_hi, vecs[i].exp_lo});
            check($sformatf("vec%0d_busy", i), 64'(bn), 64'(exp_busy(vecs[i].op)));
        end

        // Randomized ops through the scoreboard.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                default: ;
            endcase
            exp_q.push_back(ref_model(op, a, b));
            run_op(op, a, b, 1'b0, res, bn);
            check($sformatf("rand%0d_op%0d_result", i, op), res, exp_q.pop_front());
            check($sformatf("rand%0d_busy", i), 64'(bn), 64'(exp_busy(op)));
        end

        // Back-to-back: DIVU then MULTU with start never dropping.
        run_op(2'd3, 32'd1000, 32'd9, 1'b1, res, bn);
        check("b2b_first", res, ref_model(2'd3, 32'd1000, 32'd9));
        run_op(2'd1, 32'hFFFF_FFFF, 32'd3, 1'b0, res2, bn2);
        check("b2b_second", res2, {32'd2, 32'hFFFF_FFFD});
        check("b2b_second_busy", 64'(bn2), 64'(exp_busy(2'd1)));

        // Cancel at BUSY cycle 10.
        held = {bus.hi, bus.lo};
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd77; bus.b = 32'd5;
        repeat (10) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_busy_k", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.cancel = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("cancel_busy_k1", 64'(bus.busy), 64'd0);
        check("cancel_idle", 64'(bus.fsm_state), 64'd0);
        begin
            int we_seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.hilo_we) we_seen++;
            end
            check("cancel_no_we", 64'(we_seen), 64'd0);
        end
        check("cancel_hilo_kept", {bus.hi, bus.lo}, held);

        // Cancel together with start in IDLE: no acceptance.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'd2;
        @(negedge clk);
        check("cancel_idle_busy", 64'(bus.busy), 64'd0);
        check("cancel_idle_we", 64'(bus.hilo_we), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle_state", 64'(bus.fsm_state), 64'd0);

        // Reset at BUSY cycle 5.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd1234; bus.b = 32'd11;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 64'(bus.fsm_state), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_we", 64'(bus.hilo_we), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Unit is usable after the mid-operation reset.
        run_op(2'd0, 32'hFFFF_FFFE, 32'd7, 1'b0, res, bn);
        check("after_rst_mult", res, ref_model(2'd0, 32'hFFFF_FFFE, 32'd7));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit in the execute stage of the 5-stage MIPS pipeline. Executes MULT, MULTU, DIV and DIVU and writes a 64-bit {HI, LO} result. `busy` drives the hazard unit's `isMulOrDivComputingE` input, which stalls F/D/E/M/W until the result is ready. This block is the producer of that stall request and consumes it implicitly: the instruction stays in E, with `start` held high, for the whole operation.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  a mul/div instruction is valid in E; held high while stalled.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand, after forwarding.
- `b`  in  WIDTH  rt operand, after forwarding.
- `cancel`  in  1  abort the current operation (exception flush of E).
- `busy`  out  1  stall request; goes to `isMulOrDivComputingE`.
- `hilo_we`  out  1  one-cycle write strobe to the HI/LO register.
- `hi`  out  WIDTH  high result (product high, or remainder).
- `lo`  out  WIDTH  low result (product low, or quotient).

## Operation
- FSM with three states:
  - IDLE: on `start & ~cancel`, latch `a`, `b` and `op`; take operand magnitudes for signed ops; record the result signs; clear the counter; go to BUSY.
  - BUSY: one iteration per cycle, 5-bit counter.
    - Divide: restoring radix-2 divide, one quotient bit per cycle.
    - Multiply: shift-add, one multiplier bit per cycle.
    - After iteration WIDTH-1, go to DONE.
    - `cancel` goes to IDLE and discards the result.
  - DONE: apply sign correction; drive `hi`/`lo`; pulse `hilo_we`; go to IDLE unconditionally, ignoring `start` (still high from the same instruction).
- `busy = (IDLE & start & ~cancel) | BUSY`. It is combinational so the hazard unit stalls in the acceptance cycle. `busy` is 0 in DONE, so the pipeline advances at the end of DONE.
- Signed rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - Product is negated iff the signs differ.
- Divide by zero (b == 0): lo = all ones, hi = a. No exception.
- Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- `hi`/`lo` hold their last written value outside DONE, and are 0 after reset.
- `hilo_we` is high only in DONE, or in the fast-multiply case below.

## Timing
- Reset values: state IDLE, busy 0, hilo_we 0, hi 0, lo 0, counter 0.
- `rst` asserted mid-operation returns to IDLE immediately, with no `hilo_we`.
- Cycle 0 is the cycle where `start` is seen in IDLE.
- Iterative op (DIV/DIVU always; MULT/MULTU without the fast macro):
  - `busy` high in cycles 0..WIDTH (33 cycles for WIDTH = 32).
  - DONE in cycle WIDTH+1 (cycle 33 for WIDTH = 32), with `hilo_we` = 1 and valid results.
  - The next instruction enters E at cycle WIDTH+2.
- `cancel` in cycle k:
  - In BUSY: `busy` is still 1 in cycle k; IDLE from cycle k+1; no write.
  - With `start` in IDLE: no acceptance and `busy` = 0.
- A new `start` in the cycle after DONE is a new instruction and is accepted normally.

## Configuration
- Macro: `MDU_FAST_MUL_EN`.
- Defined:
  - MULT/MULTU compute with a single-cycle array multiply.
  - In IDLE with `start` and op[1] = 0: `busy` = 0, and `hilo_we` = 1 combinationally in cycle 0 with `hi`/`lo` valid. The outputs are registered into the hi/lo hold registers at the edge.
  - The FSM stays in IDLE.
  - Divides are unchanged.
- Undefined: multiplies use the iterative path, with the same latency as divide.

## Test plan
- DIVU a = 100, b = 7 -> `busy` high for 33 cycles; DONE cycle `hilo_we` = 1, lo = 14, hi = 2; next cycle IDLE.
- DIV a = -100 (0xFFFFFF9C), b = 7 -> lo = 0xFFFFFFF2 (-14), hi = 0xFFFFFFFE (-2). Also DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU a = 5, b = 0 -> lo = 0xFFFFFFFF, hi = 5, no hang.
- MULT a = 0xFFFFFFFF (-1), b = 3 -> {hi, lo} = 0xFFFFFFFF_FFFFFFFD. MULTU with the same operands -> hi = 2, lo = 0xFFFFFFFD. Check latency both with `MDU_FAST_MUL_EN` (0 busy cycles) and without it (33 busy cycles).
- `start` held high through DONE -> exactly one `hilo_we` pulse, no re-acceptance. Back-to-back DIVU then MULTU -> second op accepted the cycle after DONE.
- `cancel` at BUSY cycle 10 -> `busy` drops at cycle 11, no `hilo_we`, hi/lo unchanged. `rst` at BUSY cycle 5 -> immediate IDLE, all outputs 0.
